// File: rtl/vanilla_scoreboard_clear_gen.sv
// vanilla_scoreboard_clear_gen: remote response buffer, writeback arbitration and scoreboard clear pulses
module vanilla_scoreboard_clear_gen #(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5,
    parameter int fifo_els_p       = 4,
    parameter int starve_limit_p   = 3
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        resp_v_i,
    input  logic                        resp_float_i,
    input  logic [reg_addr_width_p-1:0] resp_id_i,
    input  logic [data_width_p-1:0]     resp_data_i,
    output logic                        resp_ready_o,
    input  logic                        idiv_v_i,
    input  logic [reg_addr_width_p-1:0] idiv_id_i,
    input  logic [data_width_p-1:0]     idiv_data_i,
    output logic                        idiv_yumi_o,
    input  logic                        fdiv_v_i,
    input  logic [reg_addr_width_p-1:0] fdiv_id_i,
    input  logic [data_width_p-1:0]     fdiv_data_i,
    output logic                        fdiv_yumi_o,
    output logic                        int_wb_v_o,
    output logic [reg_addr_width_p-1:0] int_wb_id_o,
    output logic [data_width_p-1:0]     int_wb_data_o,
    input  logic                        int_wb_yumi_i,
    output logic                        float_wb_v_o,
    output logic [reg_addr_width_p-1:0] float_wb_id_o,
    output logic [data_width_p-1:0]     float_wb_data_o,
    input  logic                        float_wb_yumi_i,
    output logic                        int_sb_clear_o,
    output logic [reg_addr_width_p-1:0] int_sb_clear_id_o,
    output logic                        float_sb_clear_o,
    output logic [reg_addr_width_p-1:0] float_sb_clear_id_o
);
    localparam int ptr_w_lp    = $clog2(fifo_els_p);
    localparam int cnt_w_lp    = ptr_w_lp + 1;
    localparam int starve_w_lp = $clog2(starve_limit_p + 1);
    localparam int entry_w_lp  = 1 + reg_addr_width_p + data_width_p;
    localparam logic [cnt_w_lp-1:0]    full_cnt_lp   = cnt_w_lp'(fifo_els_p);
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

    logic [entry_w_lp-1:0]       mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]         cnt_q, cnt_d;
    logic [starve_w_lp-1:0]      idiv_starve_q, idiv_starve_d, fdiv_starve_q, fdiv_starve_d;
    logic                        int_clr_q, int_clr_d, float_clr_q, float_clr_d;
    logic [reg_addr_width_p-1:0] int_clr_id_q, int_clr_id_d, float_clr_id_q, float_clr_id_d;
    logic                        head_float, int_head_v, float_head_v, idiv_sel, fdiv_sel;
    logic                        enq, deq;
    logic [reg_addr_width_p-1:0] head_id;
    logic [data_width_p-1:0]     head_data;

    // Arbitration, FIFO bookkeeping, starvation counters and clear next-state
    always_comb begin
        {head_float, head_id, head_data} = mem_q[rptr_q];
        resp_ready_o    = cnt_q != full_cnt_lp;
        int_head_v      = (cnt_q != '0) & ~head_float;
        float_head_v    = (cnt_q != '0) & head_float;
        idiv_sel        = idiv_v_i & (~int_head_v | (idiv_starve_q == starve_max_lp));
        fdiv_sel        = fdiv_v_i & (~float_head_v | (fdiv_starve_q == starve_max_lp));
        int_wb_v_o      = int_head_v | idiv_v_i;
        int_wb_id_o     = idiv_sel ? idiv_id_i : head_id;
        int_wb_data_o   = idiv_sel ? idiv_data_i : head_data;
        float_wb_v_o    = float_head_v | fdiv_v_i;
        float_wb_id_o   = fdiv_sel ? fdiv_id_i : head_id;
        float_wb_data_o = fdiv_sel ? fdiv_data_i : head_data;
        idiv_yumi_o     = idiv_sel & int_wb_yumi_i;
        fdiv_yumi_o     = fdiv_sel & float_wb_yumi_i;
        enq             = resp_v_i & resp_ready_o;
        deq             = (int_head_v & ~idiv_sel & int_wb_yumi_i) | (float_head_v & ~fdiv_sel & float_wb_yumi_i);
        wptr_d          = enq ? wptr_q + 1'b1 : wptr_q;
        rptr_d          = deq ? rptr_q + 1'b1 : rptr_q;
        cnt_d           = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        idiv_starve_d   = (~idiv_v_i | idiv_yumi_o) ? '0
                        : (int_head_v & ~idiv_sel) ? idiv_starve_q + 1'b1 : idiv_starve_q;
        fdiv_starve_d   = (~fdiv_v_i | fdiv_yumi_o) ? '0
                        : (float_head_v & ~fdiv_sel) ? fdiv_starve_q + 1'b1 : fdiv_starve_q;
        int_clr_d       = int_wb_v_o & int_wb_yumi_i;
        float_clr_d     = float_wb_v_o & float_wb_yumi_i;
        int_clr_id_d    = int_clr_d ? int_wb_id_o : int_clr_id_q;
        float_clr_id_d  = float_clr_d ? float_wb_id_o : float_clr_id_q;
    end

    // Response storage; contents are don't-care until the count covers them
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= {resp_float_i, resp_id_i, resp_data_i};
    end

    // Control state; reset drops buffered responses and any pending clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            cnt_q          <= '0;
            idiv_starve_q  <= '0;
            fdiv_starve_q  <= '0;
            int_clr_q      <= 1'b0;
            float_clr_q    <= 1'b0;
            int_clr_id_q   <= '0;
            float_clr_id_q <= '0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            cnt_q          <= cnt_d;
            idiv_starve_q  <= idiv_starve_d;
            fdiv_starve_q  <= fdiv_starve_d;
            int_clr_q      <= int_clr_d;
            float_clr_q    <= float_clr_d;
            int_clr_id_q   <= int_clr_id_d;
            float_clr_id_q <= float_clr_id_d;
        end
    end

    assign int_sb_clear_o      = int_clr_q;
    assign int_sb_clear_id_o   = int_clr_id_q;
    assign float_sb_clear_o    = float_clr_q;
    assign float_sb_clear_id_o = float_clr_id_q;
endmodule

// File: tb/tb_vanilla_scoreboard_clear_gen.sv
// tb_vanilla_scoreboard_clear_gen: directed and random checks against a queue-based reference model
module tb_vanilla_scoreboard_clear_gen;
    localparam int LIM = 3;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        resp_v_i, resp_float_i, resp_ready_o;
    logic [4:0]  resp_id_i;
    logic [31:0] resp_data_i;
    logic        idiv_v_i, idiv_yumi_o, fdiv_v_i, fdiv_yumi_o;
    logic [4:0]  idiv_id_i, fdiv_id_i;
    logic [31:0] idiv_data_i, fdiv_data_i;
    logic        int_wb_v_o, int_wb_yumi_i, float_wb_v_o, float_wb_yumi_i;
    logic [4:0]  int_wb_id_o, float_wb_id_o;
    logic [31:0] int_wb_data_o, float_wb_data_o;
    logic        int_sb_clear_o, float_sb_clear_o;
    logic [4:0]  int_sb_clear_id_o, float_sb_clear_id_o;

    always #5 clk_i = ~clk_i;

    vanilla_scoreboard_clear_gen dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .resp_v_i(resp_v_i), .resp_float_i(resp_float_i), .resp_id_i(resp_id_i),
        .resp_data_i(resp_data_i), .resp_ready_o(resp_ready_o),
        .idiv_v_i(idiv_v_i), .idiv_id_i(idiv_id_i), .idiv_data_i(idiv_data_i), .idiv_yumi_o(idiv_yumi_o),
        .fdiv_v_i(fdiv_v_i), .fdiv_id_i(fdiv_id_i), .fdiv_data_i(fdiv_data_i), .fdiv_yumi_o(fdiv_yumi_o),
        .int_wb_v_o(int_wb_v_o), .int_wb_id_o(int_wb_id_o), .int_wb_data_o(int_wb_data_o),
        .int_wb_yumi_i(int_wb_yumi_i),
        .float_wb_v_o(float_wb_v_o), .float_wb_id_o(float_wb_id_o), .float_wb_data_o(float_wb_data_o),
        .float_wb_yumi_i(float_wb_yumi_i),
        .int_sb_clear_o(int_sb_clear_o), .int_sb_clear_id_o(int_sb_clear_id_o),
        .float_sb_clear_o(float_sb_clear_o), .float_sb_clear_id_o(float_sb_clear_id_o)
    );

    typedef struct {bit f; bit [4:0] id; bit [31:0] d;} ent_t;
    ent_t q[$];
    int   is_m, fs_m;
    bit   ic_m, fc_m;
    bit [4:0] icid_m, fcid_m;
    int   n_cmp, n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        resp_v_i = 0; resp_float_i = 0; resp_id_i = 0; resp_data_i = 0;
        idiv_v_i = 0; idiv_id_i = 0; idiv_data_i = 0;
        fdiv_v_i = 0; fdiv_id_i = 0; fdiv_data_i = 0;
        int_wb_yumi_i = 0; float_wb_yumi_i = 0;
    endtask

    task automatic push(input bit f, input bit [4:0] id, input bit [31:0] d);
        resp_v_i = 1; resp_float_i = f; resp_id_i = id; resp_data_i = d;
    endtask

    task automatic model_reset();
        q.delete(); is_m = 0; fs_m = 0; ic_m = 0; fc_m = 0; icid_m = 0; fcid_m = 0;
    endtask

    // One clock: check combinational outputs, advance the model across the edge, check clears
    task automatic cycle();
        bit hi, hf, iw, fw, iv, fv, iacc, facc, full, rv, idv, fdv;
        bit [4:0] iid, fid;
        bit [31:0] idat, fdat;
        ent_t e;
        #2;
        hi = q.size() > 0 && !q[0].f;
        hf = q.size() > 0 && q[0].f;
        idv = idiv_v_i; fdv = fdiv_v_i;
        iw = idv && (!hi || is_m == LIM);
        fw = fdv && (!hf || fs_m == LIM);
        iv = hi || idv;
        fv = hf || fdv;
        iid = iw ? idiv_id_i : (hi ? q[0].id : 5'd0);
        idat = iw ? idiv_data_i : (hi ? q[0].d : 32'd0);
        fid = fw ? fdiv_id_i : (hf ? q[0].id : 5'd0);
        fdat = fw ? fdiv_data_i : (hf ? q[0].d : 32'd0);
        chk("resp_ready", resp_ready_o, q.size() < DEPTH);
        chk("int_wb_v", int_wb_v_o, iv);
        chk("float_wb_v", float_wb_v_o, fv);
        if (iv) begin
            chk("int_wb_id", int_wb_id_o, iid);
            chk("int_wb_data", int_wb_data_o, idat);
        end
        if (fv) begin
            chk("float_wb_id", float_wb_id_o, fid);
            chk("float_wb_data", float_wb_data_o, fdat);
        end
        iacc = iv && int_wb_yumi_i;
        facc = fv && float_wb_yumi_i;
        chk("idiv_yumi", idiv_yumi_o, iw && iacc);
        chk("fdiv_yumi", fdiv_yumi_o, fw && facc);
        full = q.size() == DEPTH;
        rv = resp_v_i;
        e = '{resp_float_i, resp_id_i, resp_data_i};
        @(posedge clk_i);
        #1;
        if ((iacc && hi && !iw) || (facc && hf && !fw)) void'(q.pop_front());
        if (rv && !full) q.push_back(e);
        is_m = (!idv || (iw && iacc)) ? 0 : (hi && !iw) ? ((is_m + 1 > LIM) ? LIM : is_m + 1) : is_m;
        fs_m = (!fdv || (fw && facc)) ? 0 : (hf && !fw) ? ((fs_m + 1 > LIM) ? LIM : fs_m + 1) : fs_m;
        ic_m = iacc;
        fc_m = facc;
        if (iacc) icid_m = iid;
        if (facc) fcid_m = fid;
        chk("int_clear", int_sb_clear_o, ic_m);
        chk("int_clear_id", int_sb_clear_id_o, icid_m);
        chk("float_clear", float_sb_clear_o, fc_m);
        chk("float_clear_id", float_sb_clear_id_o, fcid_m);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        idle();
        reset_i = 1;
        model_reset();
        #1;
        chk("rst_ready", resp_ready_o, 1);
        chk("rst_int_v", int_wb_v_o, 0);
        chk("rst_int_clr", int_sb_clear_o, 0);
        chk("rst_int_clr_id", int_sb_clear_id_o, 0);
        chk("rst_flt_clr", float_sb_clear_o, 0);
        @(posedge clk_i); #1;
        reset_i = 0;

        // single int response, yumi held
        push(0, 5, 32'hDEADBEEF); int_wb_yumi_i = 1;
        cycle();
        resp_v_i = 0;
        #1;
        chk("t1_wb_v", int_wb_v_o, 1);
        chk("t1_wb_data", int_wb_data_o, 32'hDEADBEEF);
        cycle();
        chk("t1_clear", int_sb_clear_o, 1);
        chk("t1_clear_id", int_sb_clear_id_o, 5);
        cycle();

        // fill, hold fifth, drain in order
        idle();
        for (int k = 1; k <= 4; k++) begin
            push(0, 5'(k), 32'h100 + k);
            cycle();
        end
        push(0, 5'd5, 32'h105);
        #1;
        chk("t2_full", resp_ready_o, 0);
        cycle();
        int_wb_yumi_i = 1;
        cycle();
        #1;
        chk("t2_ready_back", resp_ready_o, 1);
        cycle();
        resp_v_i = 0;
        for (int k = 0; k < 5; k++) cycle();

        // idiv starvation limit
        idle();
        push(0, 10, 32'hA); cycle();
        push(0, 11, 32'hB); cycle();
        idiv_v_i = 1; idiv_id_i = 7; idiv_data_i = 32'h77; int_wb_yumi_i = 1;
        for (int k = 0; k < 4; k++) begin
            push(0, 5'(12 + k), 32'hC0 + k);
            #1;
            chk("t3_idiv_win", idiv_yumi_o, k == 3);
            cycle();
        end
        idiv_v_i = 0; resp_v_i = 0;
        chk("t3_clear_id", int_sb_clear_id_o, 7);
        chk("t3_clear", int_sb_clear_o, 1);
        for (int k = 0; k < 4; k++) cycle();

        // float head blocks int entry
        idle();
        push(1, 2, 32'hF2); cycle();
        push(0, 20, 32'h20); cycle();
        resp_v_i = 0; idiv_v_i = 1; idiv_id_i = 4; idiv_data_i = 32'h44; int_wb_yumi_i = 1;
        #1;
        chk("t4_idiv_id", int_wb_id_o, 4);
        chk("t4_idiv_yumi", idiv_yumi_o, 1);
        cycle();
        idiv_v_i = 0;
        #1;
        chk("t4_int_blocked", int_wb_v_o, 0);
        cycle();
        float_wb_yumi_i = 1;
        cycle();
        float_wb_yumi_i = 0;
        cycle();
        cycle();

        // simultaneous int and float accept
        idle();
        push(1, 9, 32'h99); cycle();
        resp_v_i = 0; idiv_v_i = 1; idiv_id_i = 3; idiv_data_i = 32'h33;
        int_wb_yumi_i = 1; float_wb_yumi_i = 1;
        cycle();
        chk("t5_int_clr_id", int_sb_clear_id_o, 3);
        chk("t5_flt_clr_id", float_sb_clear_id_o, 9);
        chk("t5_both", {int_sb_clear_o, float_sb_clear_o}, 2'b11);

        // async reset with buffered entries
        idle();
        push(0, 21, 32'h1); cycle();
        push(1, 22, 32'h2); cycle();
        push(0, 23, 32'h3); cycle();
        idle();
        #1;
        reset_i = 1;
        model_reset();
        #1;
        chk("t6_int_v", int_wb_v_o, 0);
        chk("t6_flt_v", float_wb_v_o, 0);
        chk("t6_ready", resp_ready_o, 1);
        chk("t6_clr_id", int_sb_clear_id_o, 0);
        chk("t6_fclr_id", float_sb_clear_id_o, 0);
        #1;
        reset_i = 0;
        int_wb_yumi_i = 1; float_wb_yumi_i = 1;
        for (int k = 0; k < 3; k++) cycle();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            resp_v_i = 1'($urandom_range(0, 1));
            resp_float_i = 1'($urandom_range(0, 1));
            resp_id_i = 5'($urandom);
            resp_data_i = $urandom;
            idiv_v_i = ($urandom_range(0, 3) == 0);
            idiv_id_i = 5'($urandom);
            idiv_data_i = $urandom;
            fdiv_v_i = ($urandom_range(0, 3) == 0);
            fdiv_id_i = 5'($urandom);
            fdiv_data_i = $urandom;
            int_wb_yumi_i = ($urandom_range(0, 3) != 0);
            float_wb_yumi_i = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
